// File: rtl/fft_output_reorder.sv
// fft_output_reorder
//   Collects the bit-reversed output stream of the last SDF stage of a 32-point FFT
//   into a ping-pong register bank. Each completed frame is replayed in natural bin
//   order as a gap-free burst, with start/end-of-packet markers.
// Ports
//   clk                    clock, rising edge
//   rst_n                  asynchronous active-low reset
//   valid_i                input sample strobe
//   data_in_r, data_in_i   input sample (re/im), bit-reversed bin order
//   valid_o                output sample strobe (registered)
//   data_out_r, data_out_i output sample (re/im), natural bin order; held while idle
//   sop_o, eop_o           high with valid_o on bin 0 / bin N-1
module fft_output_reorder #(
    parameter int unsigned N     = 32,
    parameter int unsigned LOG2N = 5,
    parameter int unsigned DW    = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [DW-1:0] data_in_r,
    input  logic [DW-1:0] data_in_i,
    output logic          valid_o,
    output logic [DW-1:0] data_out_r,
    output logic [DW-1:0] data_out_i,
    output logic          sop_o,
    output logic          eop_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, wr_addr;
    logic             wr_bank_q, wr_bank_d, wr_last;
    logic [1:0]       full_q, full_d, full_set, full_clr;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d, rd_addr;
    logic             rd_en, rd_last;
    state_e           state_q, state_d;

    logic [2*DW-1:0]  mem0 [N];
    logic [2*DW-1:0]  mem1 [N];
    logic [2*DW-1:0]  rd_word;

    // ---------------- write side ----------------
    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            wr_addr[i] = wr_cnt_q[LOG2N-1-i];
        end
    end

    always_comb begin
        wr_last   = valid_i && (wr_cnt_q == LastIdx);
        wr_cnt_d  = valid_i ? wr_cnt_q + 1'b1 : wr_cnt_q;  // wraps at N
        wr_bank_d = wr_bank_q ^ wr_last;
        full_set  = '0;
        full_set[wr_bank_q] = wr_last;
    end

    // Storage is not reset; bank_full gates every read.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            if (wr_bank_q) begin
                mem1[wr_addr] <= {data_in_r, data_in_i};
            end else begin
                mem0[wr_addr] <= {data_in_r, data_in_i};
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (full_q[rd_bank_q]) state_d = StRun;
            StRun:  if (rd_last && !full_q[!rd_bank_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Idle presents address 0 on the same edge it leaves Idle, so the burst
    // starts one edge after the frame closes.
    always_comb begin
        rd_en     = (state_q == StRun) || full_q[rd_bank_q];
        rd_addr   = (state_q == StRun) ? rd_cnt_q : '0;
        rd_last   = (state_q == StRun) && (rd_cnt_q == LastIdx);
        rd_cnt_d  = rd_en ? rd_addr + 1'b1 : rd_cnt_q;     // wraps to 0 for back-to-back
        rd_bank_d = rd_bank_q ^ rd_last;
        full_clr  = '0;
        full_clr[rd_bank_q] = rd_last;
        full_d    = (full_q & ~full_clr) | full_set;       // set wins
        rd_word   = rd_bank_q ? mem1[rd_addr] : mem0[rd_addr];
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            valid_o <= rd_en;
            sop_o   <= rd_en && (rd_addr == '0);
            eop_o   <= rd_en && (rd_addr == LastIdx);
            if (rd_en) begin
                {data_out_r, data_out_i} <= rd_word;
            end
        end
    end

`ifndef SYNTHESIS
    // The drain rate guarantees a bank is never set and cleared on the same edge.
    full_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
        (full_set & full_clr) == 2'b00);
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
module tb_fft_output_reorder;

    localparam int N  = 32;
    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_in_r = '0;
    logic [DW-1:0] data_in_i = '0;
    logic          valid_o, sop_o, eop_o;
    logic [DW-1:0] data_out_r, data_out_i;

    fft_output_reorder #(.N(N), .LOG2N(5), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .sop_o      (sop_o),
        .eop_o      (eop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    int            next_free = 0;
    int            fill = 0;
    bit            checking = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] fr_re [N];
    logic [DW-1:0] fr_im [N];
    logic [DW-1:0] last_re = '0, last_im = '0;
    logic [DW-1:0] log_re[$], log_im[$];

    function automatic logic [4:0] bitrev(input logic [4:0] x);
        logic [4:0] y;
        for (int i = 0; i < 5; i++) y[i] = x[4-i];
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: a frame of N samples, sample n is bin bitrev(n). Once complete it is
    // replayed as bins 0..N-1 starting one edge after the closing write, or right
    // after the previous burst if that is later.
    task automatic model_sample(input logic [DW-1:0] r, input logic [DW-1:0] i);
        int start;
        fr_re[fill] = r;
        fr_im[fill] = i;
        fill++;
        if (fill == N) begin
            start = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
            for (int k = 0; k < N; k++) begin
                exp_t e;
                e.cyc = start + k;
                e.re  = fr_re[bitrev(5'(k))];
                e.im  = fr_im[bitrev(5'(k))];
                e.sop = (k == 0);
                e.eop = (k == N - 1);
                exp_q.push_back(e);
            end
            next_free = start + N;
            fill = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        fill = 0;
        next_free = 0;
        last_re = '0;
        last_im = '0;
    endtask

    task automatic step(input bit v, input int r, input int i);
        valid_i   = v;
        data_in_r = DW'(r);
        data_in_i = DW'(i);
        @(posedge clk);
        edge_n++;
        if (v) model_sample(DW'(r), DW'(i));
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        checking = 0;
        #1;
        chk("reset_state", {27'd0, valid_o, sop_o, eop_o, data_out_r, data_out_i}, 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        checking = 1;
    endtask

    // Compare process: every cycle, either the next expected output or an idle hold.
    always @(negedge clk) begin
        if (checking) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out", {27'd0, valid_o, sop_o, eop_o, data_out_r, data_out_i},
                    {27'd0, 1'b1, e.sop, e.eop, e.re, e.im});
                last_re = e.re;
                last_im = e.im;
            end else begin
                chk("idle", {27'd0, valid_o, sop_o, eop_o, data_out_r, data_out_i},
                    {27'd0, 3'b000, last_re, last_im});
            end
            if (valid_o) begin
                log_re.push_back(data_out_r);
                log_im.push_back(data_out_i);
            end
        end
    end

    initial begin
        #3;
        chk("reset_state", {27'd0, valid_o, sop_o, eop_o, data_out_r, data_out_i}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        checking = 1;

        // 1: one contiguous frame re=n, im=-n
        log_re.delete(); log_im.delete();
        for (int n = 0; n < N; n++) step(1, n, -n);
        chk("model_k1", 64'(exp_q[1].re), 64'd16);
        chk("model_k2", 64'(exp_q[2].re), 64'd8);
        chk("model_k31", 64'(exp_q[31].re), 64'd31);
        drain();
        chk("s1_count", 64'(log_re.size()), 64'd32);
        chk("s1_k1_re", 64'(log_re[1]), 64'd16);
        chk("s1_k1_im", 64'(log_im[1]), 64'(17'h1fff0));
        chk("s1_k2_re", 64'(log_re[2]), 64'd8);
        chk("s1_k31_re", 64'(log_re[31]), 64'd31);

        // 2: two back-to-back frames
        log_re.delete(); log_im.delete();
        for (int n = 0; n < 2 * N; n++) step(1, (n < N) ? n : (n - N) + 100, n * 3);
        drain();
        chk("s2_count", 64'(log_re.size()), 64'd64);
        chk("s2_out33", 64'(log_re[32]), 64'd100);
        chk("s2_out34", 64'(log_re[33]), 64'd116);

        // 3: valid every other cycle
        for (int n = 0; n < N; n++) begin
            step(1, n + 7, n ^ 5);
            step(0, 0, 0);
        end
        drain();

        // 4: partial frame discarded by reset, then a clean frame
        for (int n = 0; n < 10; n++) step(1, 500 + n, n);
        pulse_reset();
        log_re.delete(); log_im.delete();
        for (int n = 0; n < N; n++) step(1, n, -n);
        drain();
        chk("s4_count", 64'(log_re.size()), 64'd32);
        chk("s4_k1_re", 64'(log_re[1]), 64'd16);

        // 5: extreme values
        log_re.delete(); log_im.delete();
        for (int n = 0; n < N; n++) begin
            if (n == 0) step(1, -65536, 65535);
            else if (n == N - 1) step(1, 65535, -65536);
            else step(1, 0, 0);
        end
        drain();
        chk("s5_x0_re", 64'(log_re[0]), 64'(17'h10000));
        chk("s5_x0_im", 64'(log_im[0]), 64'(17'h0ffff));
        chk("s5_x31_re", 64'(log_re[31]), 64'(17'h0ffff));
        chk("s5_x31_im", 64'(log_im[31]), 64'(17'h10000));
        chk("s5_x5_re", 64'(log_re[5]), 64'd0);

        // Random gaps and data, with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom), int'($urandom));
            if (c == 217) pulse_reset();
        end
        for (int c = 0; c < 96; c++) step(1, int'($urandom), int'($urandom));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
